// File: rtl/fifo_reader.sv
// Read-side controller for the 256-entry byte FIFO: issues credit-checked reads and
// presents the data as a valid/ready stream. Define FIFO_READER_CNT_EN for pop_count.
module fifo_reader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             fifo_emp,
    output logic             fifo_rd_req,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
`ifdef FIFO_READER_CNT_EN
    ,
    output logic [15:0]      pop_count
`endif
);

    logic [WIDTH-1:0] buffer [2];
    logic             head;
    logic             tail;
    logic             inflight;
    logic             pop;
    logic [1:0]       occ;
    logic [1:0]       occ_next;
    logic [2:0]       credit;

    assign m_valid = (occ != 2'd0);
    assign m_data  = buffer[head];
    assign pop     = m_valid & m_ready;

    // Counting the in-flight read as already landed guarantees it a free slot.
    always_comb begin
        credit      = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        occ_next    = credit[1:0];
        fifo_rd_req = reset & enable & ~fifo_emp & (credit < 3'd2);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ      <= 2'd0;
            head     <= 1'b0;
            tail     <= 1'b0;
            inflight <= 1'b0;
        end else begin
            occ      <= occ_next;
            inflight <= fifo_rd_req;
            if (inflight) begin
                tail <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                buffer[i] <= '0;
            end
        end else if (inflight) begin
            buffer[tail] <= fifo_rd_data;
        end
    end

`ifdef FIFO_READER_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pop_count <= 16'd0;
        end else if (pop) begin
            pop_count <= pop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed self-checking bench for fifo_reader, with a behavioural 256-entry FIFO
// (synchronous read) on the read port. Define FIFO_READER_CNT_EN to test pop_count.
module tb_fifo_reader;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       fifo_emp;
    logic       fifo_rd_req;
    logic [7:0] fifo_rd_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
`ifdef FIFO_READER_CNT_EN
    logic [15:0] pop_count;
`endif

    fifo_reader #(.WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .fifo_emp     (fifo_emp),
        .fifo_rd_req  (fifo_rd_req),
        .fifo_rd_data (fifo_rd_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data)
`ifdef FIFO_READER_CNT_EN
        ,
        .pop_count    (pop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic [7:0] wr_ptr;
    logic [7:0] rd_ptr;

    assign fifo_emp = (wr_ptr == rd_ptr);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr       <= 8'd0;
            fifo_rd_data <= 8'd0;
        end else if (fifo_rd_req) begin
            fifo_rd_data <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 8'd1;
        end
    end

    int         assertions;
    int         failures;
    int         req_count;
    int         hs_count;
    logic [7:0] got [$];
    logic       last_req;
    logic       last_valid;
    logic [7:0] last_data;

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr      = wr_ptr + 8'd1;
    endtask

    // Called at a falling edge after inputs are set; samples, logs, and moves to the next falling edge.
    task automatic tick();
        #1;
        last_req   = fifo_rd_req;
        last_valid = m_valid;
        last_data  = m_data;
        if (m_valid && m_ready) begin
            got.push_back(m_data);
            hs_count++;
        end
        if (fifo_rd_req) req_count++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b0;
        enable  = 1'b0;
        m_ready = 1'b0;
        wr_ptr  = 8'd0;
        @(negedge clk);
        reset     = 1'b1;
        got.delete();
        req_count = 0;
        hs_count  = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset   = 1'b0;
        enable  = 1'b1;
        m_ready = 1'b1;
        wr_ptr  = 8'd0;
        push(8'h5A);
        @(negedge clk);
        @(negedge clk);
        #1;
        assertions++;
        if (fifo_rd_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_rd_req: got %b expected 0", fifo_rd_req);
        end
        assertions++;
        if (m_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_m_valid: got %b expected 0", m_valid);
        end
        assertions++;
        if (m_data !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_m_data: got %h expected 00", m_data);
        end
`ifdef FIFO_READER_CNT_EN
        assertions++;
        if (pop_count !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL reset_pop_count: got %h expected 0000", pop_count);
        end
`endif
        do_reset();
    endtask

    task automatic test_stream();
        bit         exp_req   [7];
        bit         exp_valid [7];
        logic [7:0] exp_data  [7];
        exp_req   = '{1, 1, 1, 1, 0, 0, 0};
        exp_valid = '{0, 0, 1, 1, 1, 1, 0};
        exp_data  = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
        do_reset();
        for (int i = 1; i <= 4; i++) push(8'(i));
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            assertions++;
            if (last_req !== exp_req[i]) begin
                failures++;
                $display("[TB] FAIL stream_req[%0d]: got %b expected %b", i, last_req, exp_req[i]);
            end
            assertions++;
            if (last_valid !== exp_valid[i]) begin
                failures++;
                $display("[TB] FAIL stream_valid[%0d]: got %b expected %b", i, last_valid, exp_valid[i]);
            end
            if (exp_valid[i]) begin
                assertions++;
                if (last_data !== exp_data[i]) begin
                    failures++;
                    $display("[TB] FAIL stream_data[%0d]: got %h expected %h", i, last_data, exp_data[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 5; i++) push(8'h31 + 8'(i));
        enable  = 1'b1;
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i >= 2) begin
                assertions++;
                if (last_valid !== 1'b1 || last_data !== 8'h31) begin
                    failures++;
                    $display("[TB] FAIL bp_hold[%0d]: got valid=%b data=%h expected valid=1 data=31",
                             i, last_valid, last_data);
                end
            end
        end
        assertions++;
        if (req_count !== 2) begin
            failures++;
            $display("[TB] FAIL bp_req_count: got %0d expected 2", req_count);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            assertions++;
            if (i < 5) begin
                if (last_valid !== 1'b1 || last_data !== 8'h31 + 8'(i)) begin
                    failures++;
                    $display("[TB] FAIL bp_resume[%0d]: got valid=%b data=%h expected valid=1 data=%h",
                             i, last_valid, last_data, 8'h31 + 8'(i));
                end
            end else if (last_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL bp_drained: got valid=%b expected 0", last_valid);
            end
        end
        assertions++;
        if (req_count !== 5) begin
            failures++;
            $display("[TB] FAIL bp_total_req: got %0d expected 5", req_count);
        end
    endtask

    task automatic test_single_write();
        do_reset();
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        assertions++;
        if (req_count !== 0 || last_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL empty_idle: got req_count=%0d valid=%b expected 0 and 0", req_count, last_valid);
        end
        push(8'hA5);
        for (int i = 0; i < 6; i++) tick();
        assertions++;
        if (req_count !== 1) begin
            failures++;
            $display("[TB] FAIL single_req_count: got %0d expected 1", req_count);
        end
        assertions++;
        if (got.size() !== 1) begin
            failures++;
            $display("[TB] FAIL single_delivered: got %0d bytes expected 1", got.size());
        end else if (got[0] !== 8'hA5) begin
            failures++;
            $display("[TB] FAIL single_data: got %h expected a5", got[0]);
        end
    endtask

    task automatic test_enable_drop();
        int cyc;
        do_reset();
        for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        enable = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        assertions++;
        if (req_count !== 5) begin
            failures++;
            $display("[TB] FAIL disable_req_count: got %0d expected 5", req_count);
        end
        assertions++;
        if (got.size() !== 5 || last_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL disable_drain: got %0d bytes valid=%b expected 5 bytes valid=0",
                     got.size(), last_valid);
        end
        enable = 1'b1;
        cyc    = 0;
        while (got.size() < 16 && cyc < 40) begin
            tick();
            cyc++;
        end
        for (int i = 0; i < 4; i++) tick();
        assertions++;
        if (got.size() !== 16) begin
            failures++;
            $display("[TB] FAIL reenable_count: got %0d bytes expected 16", got.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                assertions++;
                if (got[i] !== 8'h10 + 8'(i)) begin
                    failures++;
                    $display("[TB] FAIL reenable_order[%0d]: got %h expected %h", i, got[i], 8'h10 + 8'(i));
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 5; i++) push(8'h41 + 8'(i));
        enable  = 1'b1;
        m_ready = 1'b0;
        tick();
        tick();
        // One byte buffered and a second read in flight at this point.
        assertions++;
        if (m_valid !== 1'b1 || dut.inflight !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midreset_setup: got valid=%b inflight=%b expected 1 and 1", m_valid, dut.inflight);
        end
        reset  = 1'b0;
        wr_ptr = 8'd0;
        #1;
        assertions++;
        if (m_valid !== 1'b0 || fifo_rd_req !== 1'b0 || m_data !== 8'h00) begin
            failures++;
            $display("[TB] FAIL midreset_outputs: got valid=%b req=%b data=%h expected 0 0 00",
                     m_valid, fifo_rd_req, m_data);
        end
        @(negedge clk);
        reset = 1'b1;
        got.delete();
        push(8'h77);
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        assertions++;
        if (got.size() !== 1 || got[0] !== 8'h77) begin
            failures++;
            $display("[TB] FAIL midreset_first: got %0d bytes first=%h expected 1 byte 77",
                     got.size(), (got.size() > 0) ? got[0] : 8'h00);
        end
    endtask

`ifdef FIFO_READER_CNT_EN
    task automatic test_pop_count();
        int cyc;
        bit seen_max;
        do_reset();
        enable   = 1'b1;
        m_ready  = 1'b1;
        cyc      = 0;
        seen_max = 1'b0;
        while (hs_count < 65537 && cyc < 70000) begin
            if (8'(wr_ptr - rd_ptr) < 8'd200) push(8'(cyc));
            tick();
            got.delete();
            cyc++;
            if (hs_count == 65535 && !seen_max) begin
                seen_max = 1'b1;
                assertions++;
                if (pop_count !== 16'hFFFF) begin
                    failures++;
                    $display("[TB] FAIL pop_count_max: got %h expected ffff", pop_count);
                end
            end
        end
        m_ready = 1'b0;
        #1;
        assertions++;
        if (hs_count !== 65537 || pop_count !== 16'h0001) begin
            failures++;
            $display("[TB] FAIL pop_count_wrap: got handshakes=%0d count=%h expected 65537 and 0001",
                     hs_count, pop_count);
        end
    endtask
`endif

    initial begin
        assertions = 0;
        failures   = 0;
        req_count  = 0;
        hs_count   = 0;
        reset      = 1'b0;
        enable     = 1'b0;
        m_ready    = 1'b0;
        wr_ptr     = 8'd0;
        $display("[TB] Starting fifo_reader bench");
        test_reset();
        test_stream();
        test_backpressure();
        test_single_write();
        test_enable_drop();
        test_mid_reset();
`ifdef FIFO_READER_CNT_EN
        test_pop_count();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
